// File: rtl/newton_sqrt24.sv
// Newton-Raphson square root for a 0.24 mantissa: three 1/sqrt(d) iterations, then sqrt(d) = d * x.
// Define SQRT_EXTRA_ITER_EN to add a fourth iteration (busy to count 20, latency 23 cycles).
module newton_sqrt24 (
    input  logic        clock,
    input  logic        resetn,
    input  logic [23:0] d,
    input  logic        fsqrt,
    input  logic        enable,
    output logic [31:0] q,
    output logic        busy,
    output logic [4:0]  count,
    output logic [25:0] reg_x,
    output logic        stall
);

`ifdef SQRT_EXTRA_ITER_EN
    localparam logic [4:0] BUSY_CLR = 5'd20;
    localparam logic [4:0] LAST     = 5'd21;
`else
    localparam logic [4:0] BUSY_CLR = 5'd15;
    localparam logic [4:0] LAST     = 5'd16;
`endif
    localparam logic [25:0] THREE = 26'h3000000;

    // Seed is the fractional part of 1/sqrt at the bucket midpoint, in 1/256 steps.
    function automatic logic [7:0] seed_rom(input logic [4:0] idx);
        case (idx)
            5'd8:    return 8'hF0;
            5'd9:    return 8'hD5;
            5'd10:   return 8'hBE;
            5'd11:   return 8'hAB;
            5'd12:   return 8'h99;
            5'd13:   return 8'h8A;
            5'd14:   return 8'h7C;
            5'd15:   return 8'h6F;
            5'd16:   return 8'h64;
            5'd17:   return 8'h5A;
            5'd18:   return 8'h50;
            5'd19:   return 8'h47;
            5'd20:   return 8'h3F;
            5'd21:   return 8'h38;
            5'd22:   return 8'h31;
            5'd23:   return 8'h2A;
            5'd24:   return 8'h24;
            5'd25:   return 8'h1E;
            5'd26:   return 8'h19;
            5'd27:   return 8'h14;
            5'd28:   return 8'h0F;
            5'd29:   return 8'h0A;
            5'd30:   return 8'h06;
            5'd31:   return 8'h02;
            default: return 8'hFF;
        endcase
    endfunction

    // The iteration datapath settles over five cycles; reg_x only samples it at these counts.
    function automatic logic is_update(input logic [4:0] c);
`ifdef SQRT_EXTRA_ITER_EN
        return (c == 5'd6) || (c == 5'd11) || (c == 5'd16) || (c == 5'd21);
`else
        return (c == 5'd6) || (c == 5'd11) || (c == 5'd16);
`endif
    endfunction

    function automatic logic [31:0] round_sticky(input logic [48:0] p);
        return {p[48:18], |p[17:0]};
    endfunction

    logic [4:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic [25:0] reg_x_q, reg_x_d;
    logic [23:0] reg_d_q, reg_d_d;
    logic [48:0] ps_q, ps_d;
    logic [31:0] result_q, result_d;
    logic [25:0] t1, t2, t3, xn;

    always_comb begin
        t1 = 26'(({26'd0, reg_x_q} * {26'd0, reg_x_q}) >> 24);
        t2 = 26'(({26'd0, reg_d_q} * {24'd0, t1}) >> 24);
        t3 = THREE - t2;
        xn = 26'(({26'd0, reg_x_q} * {26'd0, t3}) >> 25);
    end

    always_comb begin
        count_d  = count_q;
        busy_d   = busy_q;
        reg_x_d  = reg_x_q;
        reg_d_d  = reg_d_q;
        ps_d     = ps_q;
        result_d = result_q;
        if (count_q == 5'd0) begin
            if (fsqrt) begin
                count_d = 5'd1;
                busy_d  = 1'b1;
            end
        end else begin
            count_d = (count_q == LAST) ? 5'd0 : count_q + 5'd1;
            if (count_q == BUSY_CLR) busy_d = 1'b0;
            if (count_q == 5'd1) begin
                reg_d_d = d;
                reg_x_d = {2'b01, seed_rom(d[23:19]), 16'd0};
            end
            if (is_update(count_q)) reg_x_d = xn;
        end
        // Bit 49 of the product never reaches q, so ps keeps only [48:0].
        if (enable) begin
            ps_d     = 49'({26'd0, reg_d_q} * {24'd0, reg_x_q});
            result_d = round_sticky(ps_q);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q  <= 5'd0;
            busy_q   <= 1'b0;
            reg_x_q  <= 26'd0;
            ps_q     <= 49'd0;
            result_q <= 32'd0;
        end else begin
            count_q  <= count_d;
            busy_q   <= busy_d;
            reg_x_q  <= reg_x_d;
            ps_q     <= ps_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clock) begin
        reg_d_q <= reg_d_d;
    end

    assign q     = result_q;
    assign busy  = busy_q;
    assign count = count_q;
    assign reg_x = reg_x_q;
    assign stall = (fsqrt & (count_q == 5'd0)) | busy_q;

endmodule
